// File: rtl/mem_stage_pkg.sv
// Shared encodings and sizing helpers for the memory-stage write-buffer controller.
package mem_stage_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DUMP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  function automatic int unsigned wb_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned wb_cnt_w(input int unsigned depth);
    return wb_ptr_w(depth) + 1;
  endfunction

  localparam int unsigned WB_DEPTH_DEF = 4;
  localparam int unsigned WB_PTR_W     = wb_ptr_w(WB_DEPTH_DEF);
  localparam int unsigned WB_CNT_W     = WB_PTR_W + 1;

endpackage

// File: rtl/wbuf_fifo.sv
// Store write-buffer: circular storage with head/tail/count and a youngest-match
// address search used for load forwarding.
module wbuf_fifo
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = WB_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  logic [ADDR_W-1:0]             enq_addr,
  input  logic [DATA_W-1:0]             enq_data,
  input  logic                          deq,
  input  logic [ADDR_W-1:0]             srch_addr,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [wb_cnt_w(DEPTH)-1:0]    count,
  output logic                          full,
  output logic                          empty,
  output logic                          hit,
  output logic [DATA_W-1:0]             hit_data
);

  localparam int unsigned PTR_W = wb_ptr_w(DEPTH);
  localparam int unsigned CNT_W = wb_cnt_w(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  idx;
  logic              enq_ok;
  logic              deq_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign enq_ok  = enq & ~full;
  assign deq_ok  = deq & ~empty;
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_ok) tail <= tail + PTR_W'(1);
      if (deq_ok) head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq_ok) - CNT_W'(deq_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      addr_q[tail] <= enq_addr;
      data_q[tail] <= enq_data;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == srch_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/mem_wbuf_stage.sv
// Memory-stage controller: write-buffered stores, forwarded or cache-issued loads,
// and drain-then-dump on halt.
module mem_wbuf_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WB_DEPTH    = WB_DEPTH_DEF,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              halt,
  output logic [DATA_W-1:0] readData,
  output logic              stall,
  output logic              err,
  output logic              dumpDone,
  output logic [ADDR_W-1:0] mAddr,
  output logic [DATA_W-1:0] mDataIn,
  output logic              mRd,
  output logic              mWr,
  output logic              mCreatedump,
  input  logic [DATA_W-1:0] mDataOut,
  input  logic              mDone,
  input  logic              mStall
);

  localparam int unsigned CNT_W    = wb_cnt_w(WB_DEPTH);
  localparam bit          ALIGN_EN = (ALIGN_CHECK != 0);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  logic [ADDR_W-1:0]  ld_addr;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic [DATA_W-1:0]  hit_data;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               hit;
  logic               halted;
  logic               illegal;
  logic               req_block;
  logic               rd_req;
  logic               wr_req;
  logic               rd_miss;
  logic               ld_done;
  logic               enq;
  logic               deq;

  assign halted    = (state == S_HALTED);
  assign illegal   = (memRead & memWrite) | (ALIGN_EN & addr[0] & (memRead | memWrite));
  assign err       = illegal & ~halted;
  assign req_block = halt | halted | illegal;
  assign rd_req    = memRead & ~req_block;
  assign wr_req    = memWrite & ~req_block;
  assign rd_miss   = rd_req & ~hit;
  assign ld_done   = (state == S_LOAD) & mDone;
  assign enq       = wr_req & ~full;

  wbuf_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq       (enq),
    .enq_addr  (addr),
    .enq_data  (writeData),
    .deq       (deq),
    .srch_addr (addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ld_addr <= '0;
    end else begin
      state <= state_nx;
      if ((state_nx == S_LOAD) && (state != S_LOAD)) ld_addr <= addr;
    end
  end

  // Next state and dequeue; a waiting load miss pre-empts further draining.
  always_comb begin
    state_nx = state;
    deq      = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt && empty)          state_nx = S_DUMP;
        else if (rd_miss) begin
          if (!mStall)              state_nx = S_LOAD;
        end else if (!empty && !mStall) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (mDone) begin
          deq      = 1'b1;
          state_nx = rd_miss ? S_LOAD : S_IDLE;
        end
      end
      S_LOAD:   if (mDone) state_nx = S_IDLE;
      S_DUMP:   state_nx = S_HALTED;
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Pipeline-facing handshake.
  always_comb begin
    stall    = 1'b0;
    readData = '0;
    if (halt && !halted && !illegal) begin
      stall = 1'b1;
    end else if (rd_req) begin
      if (hit)          readData = hit_data;
      else if (ld_done) readData = mDataOut;
      else              stall    = 1'b1;
    end else if (wr_req && full) begin
      stall = 1'b1;
    end
  end

  assign mRd         = (state == S_LOAD);
  assign mWr         = (state == S_DRAIN);
  assign mCreatedump = (state == S_DUMP);
  assign dumpDone    = halted;
  assign mAddr       = (state == S_LOAD)  ? ld_addr :
                       (state == S_DRAIN) ? head_addr : '0;
  assign mDataIn     = (state == S_DRAIN) ? head_data : '0;

endmodule

// File: tb/tb_mem_wbuf_stage.sv
// Directed bench for mem_wbuf_stage with a fixed-latency cache responder.
module tb_mem_wbuf_stage;
  import mem_stage_pkg::*;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0, writeData = '0;
  logic        memRead = 1'b0, memWrite = 1'b0, halt = 1'b0;
  logic [15:0] readData, mAddr, mDataIn;
  logic        stall, err, dumpDone, mRd, mWr, mCreatedump;
  logic [15:0] mDataOut;
  logic        mDone;
  logic        mStall = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] wlog [$];
  int unsigned rcnt;

  always #5 clk = ~clk;

  mem_wbuf_stage #(.DATA_W(16), .ADDR_W(16), .WB_DEPTH(4), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .halt(halt),
    .readData(readData), .stall(stall), .err(err), .dumpDone(dumpDone),
    .mAddr(mAddr), .mDataIn(mDataIn), .mRd(mRd), .mWr(mWr), .mCreatedump(mCreatedump),
    .mDataOut(mDataOut), .mDone(mDone), .mStall(mStall)
  );

  function automatic logic [15:0] cache_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // Cache responder: mDone pulses LAT cycles after a request is seen.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mDone <= 1'b0; mDataOut <= '0; rcnt <= 0;
    end else if ((mRd || mWr) && !mDone) begin
      if (rcnt == LAT - 1) begin
        mDone <= 1'b1; mDataOut <= mRd ? cache_val(mAddr) : 16'h0; rcnt <= 0;
      end else rcnt <= rcnt + 1;
    end else mDone <= 1'b0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) wlog.delete();
    else if (mWr && mDone) wlog.push_back({mAddr, mDataIn});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    memRead = 0; memWrite = 0; halt = 0; addr = '0; writeData = '0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    idle_in();
    #1 rst = 0;
    #2;
    total++; if ({stall, err, mRd, mWr, mCreatedump, dumpDone} !== 6'b0) begin bad++; $display("FAIL reset_ctl: got %b want 000000", {stall, err, mRd, mWr, mCreatedump, dumpDone}); end
    total++; if ({readData, mAddr, mDataIn} !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {readData, mAddr, mDataIn}); end
    total++; if (dut.u_fifo.count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count); end
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_store_fwd();
    do_reset();
    memWrite = 1; addr = 16'h0010; writeData = 16'hBEEF;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL store_stall: got %b want 0", stall); end
    tick();
    memWrite = 0; memRead = 1;
    @(negedge clk);
    total++; if (readData !== 16'hBEEF) begin bad++; $display("FAIL fwd_data: got %h want beef", readData); end
    total++; if ({stall, mRd} !== 2'b00) begin bad++; $display("FAIL fwd_stall_mrd: got %b want 00", {stall, mRd}); end
    tick(); memRead = 0;
  endtask

  task automatic test_two_stores();
    do_reset();
    memWrite = 1; addr = 16'h0030; writeData = 16'h1111; tick();
    writeData = 16'h2222; tick();
    memWrite = 0; memRead = 1;
    @(negedge clk);
    total++; if (readData !== 16'h2222 || stall !== 1'b0) begin bad++; $display("FAIL youngest_fwd: got %h stall %b want 2222 stall 0", readData, stall); end
    tick(); memRead = 0;
  endtask

  task automatic test_full();
    int n, early, stall_cyc, done_seen, maxc;
    early = 0; stall_cyc = 0; done_seen = 0; maxc = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      memWrite = 1; addr = 16'h0040 + 16'(2 * i); writeData = 16'(i + 1);
      n = 0;
      @(negedge clk);
      if (int'(dut.u_fifo.count) > maxc) maxc = int'(dut.u_fifo.count);
      while (stall && n < 20) begin
        n++;
        if (mDone) done_seen = 1;
        @(posedge clk); #1; @(negedge clk);
        if (int'(dut.u_fifo.count) > maxc) maxc = int'(dut.u_fifo.count);
      end
      if (i < 4) early += n; else stall_cyc = n;
      tick();
    end
    memWrite = 0;
    total++; if (early !== 0) begin bad++; $display("FAIL full_early_stall: got %0d want 0", early); end
    total++; if (stall_cyc !== 2) begin bad++; $display("FAIL full_stall_cycles: got %0d want 2", stall_cyc); end
    total++; if (done_seen !== 1) begin bad++; $display("FAIL full_done_before_accept: got %0d want 1", done_seen); end
    total++; if (maxc !== 4) begin bad++; $display("FAIL full_max_count: got %0d want 4", maxc); end
    for (int k = 0; k < 300 && wlog.size() < 5; k++) tick();
    total++; if (wlog.size() !== 5) begin bad++; $display("FAIL full_drain_count: got %0d want 5", wlog.size()); end
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      total++; if (wlog[i] !== {16'h0040 + 16'(2 * i), 16'(i + 1)}) begin bad++; $display("FAIL full_drain_order[%0d]: got %h want %h", i, wlog[i], {16'h0040 + 16'(2 * i), 16'(i + 1)}); end
    end
  endtask

  task automatic test_load_miss_drain();
    int done_cyc, rd_cyc, got;
    logic [15:0] rdat, rd_addr;
    logic rdone;
    done_cyc = -1; rd_cyc = -1; got = 0; rdat = '0; rd_addr = '0; rdone = 0;
    do_reset();
    memWrite = 1; addr = 16'h0050; writeData = 16'h1234; tick();
    memWrite = 0; tick();
    memRead = 1; addr = 16'h0020;
    @(negedge clk);
    total++; if ({stall, mWr} !== 2'b11) begin bad++; $display("FAIL miss_stall_inflight: got %b want 11", {stall, mWr}); end
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (mWr && mDone && done_cyc < 0) done_cyc = cyc;
      if (mRd && rd_cyc < 0) begin rd_cyc = cyc; rd_addr = mAddr; end
      if (!stall) begin got = 1; rdat = readData; rdone = mDone; break; end
      @(posedge clk); #1; @(negedge clk);
    end
    total++; if (got !== 1) begin bad++; $display("FAIL miss_timeout: got %0d want 1", got); end
    total++; if (done_cyc < 0 || rd_cyc !== done_cyc + 1) begin bad++; $display("FAIL miss_mrd_timing: got rd %0d done %0d want rd=done+1", rd_cyc, done_cyc); end
    total++; if (rd_addr !== 16'h0020) begin bad++; $display("FAIL miss_maddr: got %h want 0020", rd_addr); end
    total++; if ({rdone, rdat} !== {1'b1, 16'hA585}) begin bad++; $display("FAIL miss_data: got done %b data %h want 1 a585", rdone, rdat); end
    tick(); memRead = 0;
    total++; if (wlog.size() !== 1 || wlog[0] !== 32'h0050_1234) begin bad++; $display("FAIL miss_store_written: got %0d entries want 1 (00501234)", wlog.size()); end
  endtask

  task automatic test_errors();
    int req_seen;
    req_seen = 0;
    do_reset();
    memRead = 1; memWrite = 1; addr = 16'h0060; writeData = 16'h5555;
    @(negedge clk);
    total++; if ({err, stall, mRd, mWr} !== 4'b1000) begin bad++; $display("FAIL err_rdwr: got %b want 1000", {err, stall, mRd, mWr}); end
    tick();
    memWrite = 0; addr = 16'h0031;
    @(negedge clk);
    total++; if ({err, stall} !== 2'b10 || readData !== 16'h0) begin bad++; $display("FAIL err_misaligned_ld: got %b data %h want 10 0000", {err, stall}, readData); end
    tick();
    memRead = 0; memWrite = 1;
    @(negedge clk);
    total++; if ({err, stall} !== 2'b10) begin bad++; $display("FAIL err_misaligned_st: got %b want 10", {err, stall}); end
    tick(); idle_in();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (mRd || mWr) req_seen = 1;
    end
    total++; if (req_seen !== 0 || dut.u_fifo.count !== '0) begin bad++; $display("FAIL err_no_side_effect: got req %0d count %0d want 0 0", req_seen, dut.u_fifo.count); end
  endtask

  task automatic test_halt();
    int hs, dc, early, wr_seen;
    hs = 0; dc = 0; early = 0; wr_seen = 0;
    do_reset();
    memWrite = 1;
    for (int i = 0; i < 3; i++) begin
      addr = 16'h0070 + 16'(2 * i); writeData = 16'h0A0A + 16'(i) * 16'h0101; tick();
    end
    memWrite = 0; halt = 1;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL halt_stall: got %b want 1", stall); end
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (mWr && mDone) hs++;
      if (mCreatedump) begin dc++; if (hs < 3) early = 1; end
      if (dumpDone) break;
      @(posedge clk); #1; @(negedge clk);
    end
    total++; if (hs !== 3) begin bad++; $display("FAIL halt_handshakes: got %0d want 3", hs); end
    total++; if (dc !== 1 || early !== 0) begin bad++; $display("FAIL halt_dump_pulse: got %0d early %0d want 1 0", dc, early); end
    total++; if ({dumpDone, stall} !== 2'b10) begin bad++; $display("FAIL halt_done: got %b want 10", {dumpDone, stall}); end
    total++; if (wlog.size() !== 3 || wlog[2] !== 32'h0074_0C0C) begin bad++; $display("FAIL halt_drained: got %0d entries want 3 (last 00740c0c)", wlog.size()); end
    halt = 0; memWrite = 1; addr = 16'h0080; writeData = 16'h7777;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (mWr || stall) wr_seen = 1;
      tick();
    end
    memWrite = 0;
    total++; if ({wr_seen[0], dumpDone} !== 2'b01) begin bad++; $display("FAIL halted_ignores: got %b want 01", {wr_seen[0], dumpDone}); end
  endtask

  task automatic test_reset_mid_drain();
    int wr_seen;
    wr_seen = 0;
    do_reset();
    memWrite = 1; addr = 16'h0090; writeData = 16'h9999; tick();
    memWrite = 0;
    for (int k = 0; k < 10 && !mWr; k++) tick();
    @(negedge clk);
    total++; if (mWr !== 1'b1) begin bad++; $display("FAIL rst_mid_setup: got %b want 1", mWr); end
    #2 rst = 0;
    #1;
    total++; if ({mWr, mRd, mCreatedump, stall, err, dumpDone} !== 6'b0 || {mAddr, mDataIn, readData} !== 48'h0) begin bad++; $display("FAIL rst_mid_outputs: got %b %h want 0", {mWr, mRd, mCreatedump, stall, err, dumpDone}, {mAddr, mDataIn, readData}); end
    @(posedge clk); #1 rst = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); if (mWr) wr_seen = 1;
    end
    total++; if (wr_seen !== 0 || wlog.size() !== 0) begin bad++; $display("FAIL rst_mid_discard: got wr %0d log %0d want 0 0", wr_seen, wlog.size()); end
  endtask

  initial begin
    test_reset();
    test_store_fwd();
    test_two_stores();
    test_full();
    test_load_miss_drain();
    test_errors();
    test_halt();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wbuf_stage.md
# mem_wbuf_stage

Parametrised memory-stage controller between the pipeline's memory stage and the `mem_system` cache. It places a store write-buffer of configurable depth in front of the cache, so stores retire without waiting for `Done`. Loads are forwarded from the buffer on an address match and otherwise issued to the cache. On halt it drains the buffer before triggering the memory dump.

## Interface
- `DATA_W`, default 16: data width.
- `ADDR_W`, default 16: address width.
- `WB_DEPTH`, default 4: write-buffer entries; power of two, ≥2.
- `ALIGN_CHECK`, default 1: if 1, `addr[0]=1` on an access is an error.
- `clk` in 1: the single clock; all state on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in ADDR_W: pipeline access address.
- `writeData` in DATA_W: store data.
- `memRead`, `memWrite` in 1: pipeline load/store request, level, held stable while `stall`=1.
- `halt` in 1: level; begins drain-and-dump.
- `readData` out DATA_W: load data, valid when `memRead & ~stall & ~err`; 0 otherwise.
- `stall` out 1: pipeline must hold its request.
- `err` out 1: illegal request this cycle.
- `dumpDone` out 1: sticky; dump complete.
- `mAddr` out ADDR_W, `mDataIn` out DATA_W, `mRd` out 1, `mWr` out 1, `mCreatedump` out 1: requests to `mem_system`.
- `mDataOut` in DATA_W, `mDone` in 1, `mStall` in 1: responses from `mem_system`.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DUMP, HALTED.
- **Error requests:** `err` is combinational and asserts for either of these, with `stall`=0 and the request dropped:
  - `memRead & memWrite`;
  - `ALIGN_CHECK & addr[0] & (memRead|memWrite)`.
- **Store:** accepted the cycle `count < WB_DEPTH`, with `stall`=0. The store is enqueued at the tail at the clock edge.
  - If `count == WB_DEPTH`, `stall`=1, even if a dequeue happens the same cycle.
- **Load, forward:** the youngest buffer entry with matching `addr` supplies `readData` the same cycle, `stall`=0.
  - The entry currently being drained still counts for forwarding until its `mDone`.
- **Load, miss:** `stall`=1.
  - IDLE with `mStall`=0 → LOAD.
  - In DRAIN, the load waits for the current store's `mDone`, then → LOAD. Loads take priority over further drain.
  - In LOAD, `mRd`=1 with `mAddr=addr`. On `mDone`: `readData=mDataOut`, `stall`=0 that cycle, → IDLE.
- **Drain:** IDLE with `count>0`, no pending load miss, and `mStall`=0 → DRAIN.
  - `mWr`=1 with the head entry on `mAddr`/`mDataIn`, held stable until `mDone`.
  - On `mDone`: dequeue the head, → IDLE.
- One outstanding cache request at most. `mRd` and `mWr` are never both 1.
- **Halt:**
  - While `halt`=1 and state ≠ HALTED: `stall`=1 and no new requests are accepted.
  - The buffer drains as normal.
  - When `count==0` and IDLE → DUMP.
  - DUMP: `mCreatedump`=1 for exactly one cycle → HALTED.
  - HALTED: `dumpDone`=1, `stall`=0, and all requests are ignored until reset.
- **Simultaneous enqueue and dequeue:** `count` is unchanged and both pointers advance. Pointers wrap modulo `WB_DEPTH`.

## Timing
- Reset values: `count`=0, pointers=0, state=IDLE, `mRd=mWr=mCreatedump=0`, `stall`=0, `err`=0, `readData`=0, `dumpDone`=0.
- **Reset mid-request:** the buffer contents are discarded. `mRd`/`mWr` drop asynchronously.
- **Latency:**
  - Store hit in buffer: 0 stall cycles.
  - Forwarded load: 0 stall cycles.
  - Load miss from IDLE: 1 cycle to enter LOAD, plus the cache latency to `mDone`.
  - Drained stores are invisible to the pipeline.
- Outputs `mAddr`, `mDataIn`, `mRd`, `mWr`, `mCreatedump` are decoded from registered state and the head entry. They are glitch-free within a cycle.
- `mDone` is sampled only in LOAD and DRAIN and ignored elsewhere.

## Structure
- Package `mem_stage_pkg`:
  - FSM state encoding (3 bits);
  - `WB_PTR_W = $clog2(WB_DEPTH)`;
  - count width `WB_PTR_W+1`.
- Sub-module `wbuf_fifo`:
  - storage arrays, head/tail pointers, count;
  - full/empty flags;
  - combinational youngest-match search that returns hit and data.
- The FSM, error decode and output muxing stay in `mem_wbuf_stage`.

## Test plan
- **Store then load, same address:** store 0x0010←0xBEEF, next cycle load 0x0010 → `readData`=0xBEEF, `stall`=0, no `mRd`.
- **Full buffer:** 5 back-to-back stores with `WB_DEPTH`=4 and a 3-cycle cache → 5th store sees `stall`=1 until the first `mDone`, then is accepted; `count` never exceeds 4.
- **Load miss during drain:** load 0x0020 while a store drain is in flight → `mRd` asserts the cycle after the store's `mDone`, `readData`=`mDataOut` on the load's `mDone`.
- **Two stores to 0x0030 (0x1111, then 0x2222), then load 0x0030** → 0x2222.
- **Errors:** `memRead=memWrite=1`, or `addr`=0x0031 load → `err`=1, `stall`=0, no cache request, buffer unchanged.
- **Halt with 3 buffered stores** → 3 `mWr` handshakes, then `mCreatedump` high exactly 1 cycle, then `dumpDone`=1. Reset asserted mid-drain → all outputs return to reset values immediately.
